// File: rtl/pc_pkg.sv
// pc_pkg
//   Shared definitions for the program-counter unit.
//   pc_src_t  : which source drives the PC register on the next edge.
//   DEFAULT_STEP / DEFAULT_RESET_VEC : default sequential increment and
//   reset vector used by pc_unit_ras parameters.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_SEQ    = 3'd1,
        PC_LOAD   = 3'd2,
        PC_BRANCH = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_src_t;

    localparam int unsigned DEFAULT_STEP      = 4;
    localparam int unsigned DEFAULT_RESET_VEC = 0;

endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack
//   Circular LIFO of return addresses. A push while full overwrites the
//   oldest entry (the write slot has wrapped onto it) and sets the sticky
//   ovf flag; a pop while empty leaves the stack untouched and sets the
//   sticky unf flag. Flags clear only on clear.
// Ports
//   clock, clear   : clock and synchronous active-high reset
//   push, pop      : one-cycle requests; never asserted together by the parent
//   push_data      : address written on push
//   top_data       : newest entry (valid when !empty)
//   count          : number of valid entries, 0..DEPTH
//   empty, full    : decoded from count
//   ovf, unf       : sticky overflow / underflow flags
module return_addr_stack #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               push_data,
    output logic [W-1:0]               top_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;          // next write slot; newest entry is ptr-1

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign top_data = mem[ptr - PTR_W'(1)];

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clock) begin
        if (!clear && push) begin
            mem[ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                ptr   <= ptr - PTR_W'(1);
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit_ras.sv
// pc_unit_ras
//   Program counter with sequential advance, bus load, conditional relative
//   branch, and call/return through an internal return-address stack.
//   Request priority: clear > stall > load > ret > call > branch > enable.
//   Every update appears on PC one cycle after the requesting edge, with
//   PCinc high in that same cycle.
// Ports
//   clock, clear          : clock and synchronous active-high reset
//   enable                : PC <= PC + STEP
//   stall                 : freeze PC, stack and flags
//   load, bus_in          : PC <= bus_in
//   branch, con, offset   : PC <= PC + STEP + (con ? offset : 0)
//   call                  : push PC + STEP, PC <= bus_in
//   ret                   : PC <= popped entry (PC + STEP if stack empty)
//   PC, PCinc             : current PC, pulse when PC was written last edge
//   ras_count/empty/full  : stack occupancy
//   ras_ovf/ras_unf       : sticky stack overflow / underflow
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          STEP      = DEFAULT_STEP,
    parameter logic [ADDR_W-1:0]    RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC),
    parameter int unsigned          RAS_DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         enable,
    input  logic                         stall,
    input  logic                         load,
    input  logic [ADDR_W-1:0]            bus_in,
    input  logic                         branch,
    input  logic                         con,
    input  logic [ADDR_W-1:0]            offset,
    input  logic                         call,
    input  logic                         ret,
    output logic [ADDR_W-1:0]            PC,
    output logic                         PCinc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    pc_src_t           pc_src;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push;
    logic              ras_pop;

    assign pc_seq = PC + STEP_V;

    // Priority decode; clear is handled directly in the registers.
    always_comb begin
        pc_src = PC_HOLD;
        if (stall)       pc_src = PC_HOLD;
        else if (load)   pc_src = PC_LOAD;
        else if (ret)    pc_src = PC_RET;
        else if (call)   pc_src = PC_CALL;
        else if (branch) pc_src = PC_BRANCH;
        else if (enable) pc_src = PC_SEQ;
    end

    // A return on an empty stack falls through to the next instruction.
    always_comb begin
        pc_next = PC;
        case (pc_src)
            PC_SEQ:    pc_next = pc_seq;
            PC_LOAD:   pc_next = bus_in;
            PC_BRANCH: pc_next = con ? (pc_seq + offset) : pc_seq;
            PC_CALL:   pc_next = bus_in;
            PC_RET:    pc_next = ras_empty ? pc_seq : ras_top;
            default:   pc_next = PC;
        endcase
    end

    assign ras_push = (pc_src == PC_CALL);
    assign ras_pop  = (pc_src == PC_RET);

    always_ff @(posedge clock) begin
        if (clear) begin
            PC    <= RESET_VEC;
            PCinc <= 1'b0;
        end else begin
            PC    <= pc_next;
            PCinc <= (pc_src != PC_HOLD);
        end
    end

    return_addr_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .clear     (clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top_data  (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

endmodule

// File: tb/tb_pc_unit_ras.sv
module tb_pc_unit_ras;

    localparam int DEPTH = 8;
    localparam int EW    = 41;   // {pc[31:0], pcinc, count[3:0], empty, full, ovf, unf}

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic        stall = 1'b0;
    logic        load = 1'b0;
    logic [31:0] bus_in = '0;
    logic        branch = 1'b0;
    logic        con = 1'b0;
    logic [31:0] offset = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] PC;
    logic        PCinc;
    logic [3:0]  ras_count;
    logic        ras_empty, ras_full, ras_ovf, ras_unf;

    pc_unit_ras dut (
        .clock(clock), .clear(clear), .enable(enable), .stall(stall),
        .load(load), .bus_in(bus_in), .branch(branch), .con(con),
        .offset(offset), .call(call), .ret(ret), .PC(PC), .PCinc(PCinc),
        .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    // clock / reset
    always #5 clock = ~clock;

    // reference model: stack as a plain queue, oldest at front
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_stack[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    // scoreboard
    logic [EW-1:0] exp_q[$];
    string         tag_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic logic [EW-1:0] pack(input logic [31:0] pc, input logic inc,
                                           input int cnt, input logic o, input logic u);
        logic [3:0] c;
        c = 4'(cnt);
        return {pc, inc, c, (cnt == 0), (cnt == DEPTH), o, u};
    endfunction

    // driver: drive one cycle of inputs at negedge and queue the expected result
    task automatic cyc(input logic c_clr, input logic c_stall, input logic c_load,
                       input logic [31:0] c_bus, input logic c_br, input logic c_con,
                       input logic [31:0] c_off, input logic c_call, input logic c_ret,
                       input logic c_en, input string tag);
        logic inc;
        @(negedge clock);
        clear = c_clr; stall = c_stall; load = c_load; bus_in = c_bus;
        branch = c_br; con = c_con; offset = c_off; call = c_call; ret = c_ret;
        enable = c_en;
        inc = 1'b0;
        if (c_clr) begin
            m_pc = 32'h0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (c_stall) begin
            inc = 1'b0;
        end else if (c_load) begin
            inc = 1'b1; m_pc = c_bus;
        end else if (c_ret) begin
            inc = 1'b1;
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_pc = m_pc + 32'd4; m_unf = 1'b1; end
        end else if (c_call) begin
            inc = 1'b1;
            if (m_stack.size() == DEPTH) begin
                void'(m_stack.pop_front());
                m_ovf = 1'b1;
            end
            m_stack.push_back(m_pc + 32'd4);
            m_pc = c_bus;
        end else if (c_br) begin
            inc = 1'b1;
            m_pc = m_pc + 32'd4 + (c_con ? c_off : 32'd0);
        end else if (c_en) begin
            inc = 1'b1; m_pc = m_pc + 32'd4;
        end
        exp_q.push_back(pack(m_pc, inc, m_stack.size(), m_ovf, m_unf));
        tag_q.push_back(tag);
    endtask

    task automatic do_clear();                  cyc(1,0,0,0,0,0,0,0,0,0,"clear");  endtask
    task automatic do_en();                     cyc(0,0,0,0,0,0,0,0,0,1,"enable"); endtask
    task automatic do_idle();                   cyc(0,0,0,0,0,0,0,0,0,0,"hold");   endtask
    task automatic do_load(input logic [31:0] v); cyc(0,0,1,v,0,0,0,0,0,0,"load");  endtask
    task automatic do_call(input logic [31:0] v); cyc(0,0,0,v,0,0,0,1,0,0,"call");  endtask
    task automatic do_ret();                    cyc(0,0,0,0,0,0,0,0,1,0,"ret");    endtask
    task automatic do_branch(input logic c, input logic [31:0] o);
        cyc(0,0,0,0,1,c,o,0,0,0,"branch");
    endtask

    // monitor: compare every edge that has an expectation queued
    always @(posedge clock) begin
        logic [EW-1:0] got, exp;
        string         tag;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            got = {PC, PCinc, ras_count, ras_empty, ras_full, ras_ovf, ras_unf};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL %s @%0t: got pc=%h inc=%b cnt=%0d e/f/o/u=%b exp pc=%h inc=%b cnt=%0d e/f/o/u=%b",
                         tag, $time, got[40:9], got[8], got[7:4], got[3:0],
                         exp[40:9], exp[8], exp[7:4], exp[3:0]);
            end
        end
    end

    initial begin
        // sequential advance after clear
        do_clear();
        do_en(); do_en(); do_en();
        do_idle();
        // relative branch taken / not taken
        do_load(32'h100); do_branch(1'b1, 32'hFFFF_FFF0);
        do_load(32'h100); do_branch(1'b0, 32'hFFFF_FFF0);
        // single call / return
        do_load(32'h40); do_call(32'h200); do_ret();
        // overflow: 9 calls, then 8 returns newest first
        for (int i = 0; i < 9; i++) do_call(32'h1000 + 32'(i) * 32'h100);
        for (int i = 0; i < 8; i++) do_ret();
        // underflow is sticky until clear
        do_clear(); do_load(32'h10); do_ret();
        do_en(); do_call(32'h300); do_idle();
        // load wins over ret and enable; stack untouched
        cyc(0,0,1,32'h500,0,0,0,0,1,1,"load_ret_en");
        do_ret();
        // stall freezes everything
        do_call(32'h600);
        cyc(0,1,1,32'h700,1,1,32'h8,1,1,1,"stall_all");
        // silent wrap-around
        do_load(32'hFFFF_FFFC); do_en();
        // clear during call
        do_call(32'h800);
        cyc(1,0,0,32'h900,0,0,0,1,0,0,"clear_call");
        do_idle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rb, ro;
            rb = $urandom() & 32'hFFFF_FFFC;
            ro = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FF00 | ($urandom() & 32'hFC))
                                             : ($urandom() & 32'h3FC);
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0, rb, $urandom_range(0, 3) == 0,
                1'($urandom_range(0, 1)), ro, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, "random");
        end

        // drain with a bounded wait
        @(negedge clock);
        clear = 0; stall = 0; load = 0; branch = 0; call = 0; ret = 0; enable = 0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
